approx_mul8_row_reducer: RTL and testbench

Final reduction stage of the approximate unsigned 8x8 multiplier. It accepts the four half-adder arrays produced by the partial-product/HA stage, which are eight weighted rows. It sums them in a two-stage valid/ready pipeline and emits the 16-bit product. An overflow flag is raised when the rows sum past 16 bits.

---
 rtl/approx_mul_pkg.sv | 23 ++
 rtl/approx_mul8_pair_adder.sv | 18 +
 rtl/approx_mul8_row_reducer.sv | 78 +++++++
 tb/tb_approx_mul8_row_reducer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/approx_mul_pkg.sv
// Shared constants, row type and weight helper for the approximate 8x8 multiplier.
// The HA-array stage and the row reducer both use ha_row_t.
package approx_mul_pkg;

  localparam int N_ARR  = 4;
  localparam int T_W    = 9;
  localparam int B_W    = 7;
  localparam int P_W    = 16;
  localparam int SUM_W  = 18;
  localparam int PSUM_W = 17;
  // A bottom row sits two weight positions above its top row.
  localparam int B_OFS  = 2;

  typedef struct packed {
    logic [T_W-1:0] t;
    logic [B_W-1:0] b;
  } ha_row_t;

  function automatic int arr_weight(input int j);
    return 2 * j;
  endfunction

endpackage

// File: rtl/approx_mul8_pair_adder.sv
// Aligns and sums two neighbouring HA arrays relative to the lower one's weight.
// The caller reapplies the lower array's absolute weight.
module approx_mul8_pair_adder
  import approx_mul_pkg::*;
(
  input  ha_row_t           lo,
  input  ha_row_t           hi,
  output logic [PSUM_W-1:0] sum
);

  localparam int HI_SHIFT = arr_weight(1) - arr_weight(0);

  assign sum = PSUM_W'(lo.t)
             + (PSUM_W'(lo.b) << B_OFS)
             + (PSUM_W'(hi.t) << HI_SHIFT)
             + (PSUM_W'(hi.b) << (HI_SHIFT + B_OFS));

endmodule

// File: rtl/approx_mul8_row_reducer.sv
// Two-stage valid/ready reduction of the eight weighted HA rows into the
// 16-bit product plus an overflow flag.
module approx_mul8_row_reducer #(
  parameter int N_ARR = 4,
  parameter int T_W   = 9,
  parameter int B_W   = 7,
  parameter int P_W   = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [T_W-1:0] ha_array_0_t,
  input  logic [T_W-1:0] ha_array_1_t,
  input  logic [T_W-1:0] ha_array_2_t,
  input  logic [T_W-1:0] ha_array_3_t,
  input  logic [B_W-1:0] ha_array_0_b,
  input  logic [B_W-1:0] ha_array_1_b,
  input  logic [B_W-1:0] ha_array_2_b,
  input  logic [B_W-1:0] ha_array_3_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P_W-1:0] product,
  output logic           ovf
);

  import approx_mul_pkg::*;

  // pb is held without its base weight; it is shifted back in S2.
  localparam int PB_SHIFT = arr_weight(N_ARR / 2);

  ha_row_t arr0, arr1, arr2, arr3;
  logic [PSUM_W-1:0] pa_next, pb_next;
  logic [PSUM_W-1:0] pa, pb;
  logic [SUM_W-1:0]  sum_next;
  logic              s1_valid;
  logic              s1_adv, s2_adv;

  assign arr0 = '{t: ha_array_0_t, b: ha_array_0_b};
  assign arr1 = '{t: ha_array_1_t, b: ha_array_1_b};
  assign arr2 = '{t: ha_array_2_t, b: ha_array_2_b};
  assign arr3 = '{t: ha_array_3_t, b: ha_array_3_b};

  approx_mul8_pair_adder u_pair_a (.lo(arr0), .hi(arr1), .sum(pa_next));
  approx_mul8_pair_adder u_pair_b (.lo(arr2), .hi(arr3), .sum(pb_next));

  // Handshake: a beat moves on an edge where valid && ready. A stage advances
  // when it is empty or its successor advances; in_ready never looks at
  // in_valid, and held output data is frozen while out_valid && !out_ready.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  assign sum_next = SUM_W'(pa) + (SUM_W'(pb) << PB_SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      pa        <= '0;
      pb        <= '0;
      out_valid <= 1'b0;
      product   <= '0;
      ovf       <= 1'b0;
    end else begin
      if (s2_adv) begin
        out_valid <= s1_valid;
        product   <= sum_next[P_W-1:0];
        ovf       <= |sum_next[SUM_W-1:P_W];
      end
      if (s1_adv) begin
        s1_valid <= in_valid;
        pa       <= pa_next;
        pb       <= pb_next;
      end
    end
  end

endmodule

// File: tb/tb_approx_mul8_row_reducer.sv
// Bench for approx_mul8_row_reducer: directed vectors, backpressure and reset
// sequences, then randomized traffic against an aligned-sum reference.
module tb_approx_mul8_row_reducer;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0][8:0]  t_r;
  logic [3:0][6:0]  b_r;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      product;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  logic [16:0] exp_q[$];

  typedef struct packed {
    logic [3:0][8:0] t;
    logic [3:0][6:0] b;
    logic [15:0]     exp_p;
    logic            exp_o;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  approx_mul8_row_reducer dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ha_array_0_t (t_r[0]),
    .ha_array_1_t (t_r[1]),
    .ha_array_2_t (t_r[2]),
    .ha_array_3_t (t_r[3]),
    .ha_array_0_b (b_r[0]),
    .ha_array_1_b (b_r[1]),
    .ha_array_2_b (b_r[2]),
    .ha_array_3_b (b_r[3]),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .ovf          (ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain weighted sum: array j counts t at 2^(2j) and b at 2^(2j+2).
  function automatic logic [16:0] ref_model(input logic [3:0][8:0] t, input logic [3:0][6:0] b);
    int s;
    logic [15:0] p;
    s = 0;
    for (int j = 0; j < 4; j++)
      s += (int'(t[j]) * (1 << (2 * j))) + (int'(b[j]) * (1 << (2 * j + 2)));
    p = s[15:0];
    return {(s >= 65536), p};
  endfunction

  task automatic clear_rows();
    t_r = '0;
    b_r = '0;
  endtask

  initial begin
    int sent, got, cycles;
    logic held_v;
    logic [16:0] held;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    clear_rows();

    for (int i = 0; i < 11; i++) vecs[i] = '0;
    vecs[0].t[0] = 9'h001;                         vecs[0].exp_p = 16'h0001;
    vecs[1].b[3] = 7'h40;                          vecs[1].exp_p = 16'h4000;
    for (int j = 0; j < 4; j++) begin
      vecs[2].t[j] = 9'h1FF; vecs[2].b[j] = 7'h7F;
    end
    vecs[2].exp_p = 16'h5257; vecs[2].exp_o = 1'b1;
    vecs[3].t[1] = 9'h001;                         vecs[3].exp_p = 16'h0004;
    vecs[4].b[0] = 7'h01;                          vecs[4].exp_p = 16'h0004;
    vecs[5].t[2] = 9'h100;                         vecs[5].exp_p = 16'h1000;
    vecs[6].t[3] = 9'h1FF;                         vecs[6].exp_p = 16'h7FC0;
    vecs[7].b[2] = 7'h7F; vecs[7].b[3] = 7'h7F;    vecs[7].exp_p = 16'h9EC0;
    vecs[8].t[3] = 9'h1FF; vecs[8].b[3] = 7'h7F;   vecs[8].exp_p = 16'hFEC0;
    vecs[9].t[3] = 9'h1FF; vecs[9].b[3] = 7'h7F; vecs[9].t[0] = 9'h140;
    vecs[9].exp_p = 16'h0000; vecs[9].exp_o = 1'b1;
    vecs[10].t[3] = 9'h1FF; vecs[10].b[3] = 7'h7F; vecs[10].t[0] = 9'h13F;
    vecs[10].exp_p = 16'hFFFF;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_product", product, 0);
    check("rst_ovf", ovf, 0);

    // Directed vectors: one item each, latency two edges, valid for one cycle
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      t_r = vecs[i].t; b_r = vecs[i].b;
      in_valid = 1'b1; out_ready = 1'b1;
      #1 check($sformatf("vec%0d_in_ready", i), in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0; clear_rows();
      #1 check($sformatf("vec%0d_early", i), out_valid, 0);
      @(negedge clk);
      #1;
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_product", i), product, vecs[i].exp_p);
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].exp_o);
      check($sformatf("vec%0d_model", i), {vecs[i].exp_o, vecs[i].exp_p}, ref_model(vecs[i].t, vecs[i].b));
      @(negedge clk);
      #1 check($sformatf("vec%0d_once", i), out_valid, 0);
    end

    // Backpressure: 1,2,3 with out_ready low, then drain in order
    @(negedge clk);
    clear_rows(); t_r[0] = 9'd1; in_valid = 1'b1; out_ready = 1'b0;
    #1 check("bp_rdy1", in_ready, 1);
    @(negedge clk);
    t_r[0] = 9'd2;
    #1 check("bp_rdy2", in_ready, 1);
    @(negedge clk);
    t_r[0] = 9'd3;
    #1 check("bp_full", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("bp_hold_rdy", in_ready, 0);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_product", product, 1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy", in_ready, 1);
    check("bp_out1", {out_valid, product}, {1'b1, 16'd1});
    @(negedge clk);
    in_valid = 1'b0; clear_rows();
    #1 check("bp_out2", {out_valid, product}, {1'b1, 16'd2});
    @(negedge clk);
    #1 check("bp_out3", {out_valid, product}, {1'b1, 16'd3});
    @(negedge clk);
    #1 check("bp_empty", out_valid, 0);

    // Reset while both stages are full
    @(negedge clk);
    t_r[0] = 9'd5; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    t_r[0] = 9'd6;
    @(negedge clk);
    in_valid = 1'b0; clear_rows();
    #1 check("mid_full", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_product", product, 0);
    check("mid_rst_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1 check("mid_no_stale", out_valid, 0);
    end

    // Randomized traffic with random backpressure
    sent = 0; got = 0; cycles = 0; held_v = 1'b0; held = '0;
    while (got < 1000 && cycles < 20000) begin
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
        t_r[j] = 9'($urandom_range(0, 511));
        b_r[j] = 7'($urandom_range(0, 127));
      end
      in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      check("rand_in_ready", in_ready, !(exp_q.size() == 2 && !out_ready));
      if (held_v) check("rand_stall_hold", {out_valid, ovf, product}, {1'b1, held});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("rand_spurious", 1, 0);
        else check("rand_out", {ovf, product}, exp_q.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(t_r, b_r));
        sent++;
      end
      held_v = out_valid && !out_ready;
      held = {ovf, product};
      cycles++;
    end
    check("rand_count", got, 1000);
    check("rand_queue_empty", exp_q.size(), 0);

    @(negedge clk);
    in_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
